// File: rtl/request_queue.sv
`default_nettype none
// ============================================================================
// request_queue : 16-slot aging request table feeding the priority stage
// Rev 1.0
// ============================================================================
module request_queue #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 64,
  parameter int AGE_PERIOD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_write,
  input  logic [1:0]        in_prio,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [15:0]       slot_valid,
  output logic [95:0]       slot_age,
  output logic [47:0]       slot_unsched,
  input  logic              issue_valid,
  input  logic [3:0]        issue_slot,
  output logic              out_valid,
  output logic              out_write,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        count,
  output logic              issue_err
);

  localparam int              c_TICK_W   = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(AGE_PERIOD - 1);
  localparam logic [5:0]      c_AGE_MAX  = 6'd63;

  logic [15:0]         valid_q,   valid_d;
  logic [5:0]          age_q     [16];
  logic [5:0]          age_d     [16];
  logic [2:0]          unsched_q [16];
  logic [2:0]          unsched_d [16];
  logic [ADDR_W-1:0]   addr_q    [16];
  logic [DATA_W-1:0]   data_q    [16];
  logic [c_TICK_W-1:0] tick_q;
  logic [4:0]          count_q;
  logic                issue_err_q;
  logic                out_valid_q, out_write_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [DATA_W-1:0]   out_data_q;

  logic       w_tick;
  logic       w_do_ins;
  logic       w_do_iss;
  logic [3:0] w_ins_slot;

  assign in_ready = ~&valid_q;
  assign w_tick   = (tick_q == c_TICK_MAX);
  assign w_do_ins = in_valid & in_ready;
  assign w_do_iss = issue_valid & valid_q[issue_slot];

  // Lowest free slot of the pre-edge state; never the slot being retired.
  always_comb begin
    w_ins_slot = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!valid_q[i]) w_ins_slot = 4'(i);
    end
  end

  always_comb begin
    valid_d   = valid_q;
    age_d     = age_q;
    unsched_d = unsched_q;
    for (int i = 0; i < 16; i++) begin
      if (w_tick && valid_q[i] && (age_q[i] != c_AGE_MAX)) age_d[i] = age_q[i] + 6'd1;
    end
    if (w_do_iss) begin
      valid_d[issue_slot]   = 1'b0;
      age_d[issue_slot]     = 6'd0;
      unsched_d[issue_slot] = 3'd0;
    end
    if (w_do_ins) begin
      valid_d[w_ins_slot]   = 1'b1;
      age_d[w_ins_slot]     = 6'd0;
      unsched_d[w_ins_slot] = {in_prio, in_write};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      tick_q      <= '0;
      count_q     <= '0;
      issue_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_write_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        age_q[i]     <= '0;
        unsched_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      age_q       <= age_d;
      unsched_q   <= unsched_d;
      tick_q      <= w_tick ? '0 : tick_q + 1'b1;
      count_q     <= count_q + 5'(w_do_ins) - 5'(w_do_iss);
      out_valid_q <= w_do_iss;
      if (issue_valid && !valid_q[issue_slot]) issue_err_q <= 1'b1;
      if (w_do_iss) begin
        out_write_q <= unsched_q[issue_slot][0];
        out_addr_q  <= addr_q[issue_slot];
        out_data_q  <= data_q[issue_slot];
      end
    end
  end

  // Payload storage is only meaningful under valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_do_ins) begin
      addr_q[w_ins_slot] <= in_addr;
      data_q[w_ins_slot] <= in_data;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign slot_age[6*g +: 6]     = age_q[g];
    assign slot_unsched[3*g +: 3] = unsched_q[g];
  end

  assign slot_valid = valid_q;
  assign out_valid  = out_valid_q;
  assign out_write  = out_write_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign count      = count_q;
  assign issue_err  = issue_err_q;

endmodule
`default_nettype wire

// File: tb/tb_request_queue.sv
`default_nettype none
// ============================================================================
// tb_request_queue : directed self-checking bench for request_queue
// Rev 1.0
// ============================================================================
module tb_request_queue;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid, in_ready, in_write;
  logic [1:0]        in_prio;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [15:0]       slot_valid;
  logic [95:0]       slot_age;
  logic [47:0]       slot_unsched;
  logic              issue_valid;
  logic [3:0]        issue_slot;
  logic              out_valid, out_write;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        count;
  logic              issue_err;

  int checks = 0;
  int errors = 0;

  request_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AGE_PERIOD(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write),
    .in_prio(in_prio), .in_addr(in_addr), .in_data(in_data),
    .slot_valid(slot_valid), .slot_age(slot_age), .slot_unsched(slot_unsched),
    .issue_valid(issue_valid), .issue_slot(issue_slot),
    .out_valid(out_valid), .out_write(out_write), .out_addr(out_addr),
    .out_data(out_data), .count(count), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_write = 0; in_prio = 0; in_addr = '0; in_data = '0;
    issue_valid = 0; issue_slot = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    step(); step();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #3;
    checks++;
    if ({slot_valid, count, out_valid, issue_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%h count=%0d ov=%b err=%b, want 0", slot_valid, count, out_valid, issue_err);
    end
    checks++;
    if ({slot_age, slot_unsched} !== '0) begin
      errors++;
      $display("FAIL reset_fields: age=%h unsched=%h, want 0", slot_age, slot_unsched);
    end
    step();
    reset_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_insert();
    do_reset();
    in_valid = 1; in_write = 0; in_prio = 2; in_addr = 28'h100; in_data = 64'h55;
    step();
    idle_inputs();
    checks++;
    if (slot_valid !== 16'h0001 || slot_unsched[2:0] !== 3'b100 || slot_age[5:0] !== 6'd0 || count !== 5'd1) begin
      errors++;
      $display("FAIL insert_first: valid=%h uns=%b age=%0d count=%0d, want 0001 100 0 1",
               slot_valid, slot_unsched[2:0], slot_age[5:0], count);
    end
    issue_valid = 1; issue_slot = 0;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_write !== 1'b0 || out_addr !== 28'h100 || slot_valid !== 16'h0 || count !== 5'd0) begin
      errors++;
      $display("FAIL issue_first: ov=%b w=%b addr=%h valid=%h count=%0d, want 1 0 100 0000 0",
               out_valid, out_write, out_addr, slot_valid, count);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_addr !== 28'h100) begin
      errors++;
      $display("FAIL out_hold: ov=%b addr=%h, want 0 100", out_valid, out_addr);
    end
  endtask

  task automatic test_aging();
    do_reset();
    in_valid = 1; in_prio = 0; in_addr = 28'h7;
    step();
    idle_inputs();
    checks++;
    if (slot_age[5:0] !== 6'd0) begin errors++; $display("FAIL age_insert: got %0d want 0", slot_age[5:0]); end
    step(); step();
    checks++;
    if (slot_age[5:0] !== 6'd0) begin errors++; $display("FAIL age_pre_tick: got %0d want 0", slot_age[5:0]); end
    step();
    checks++;
    if (slot_age[5:0] !== 6'd1) begin errors++; $display("FAIL age_first_tick: got %0d want 1", slot_age[5:0]); end
    repeat (4*61) step();
    checks++;
    if (slot_age[5:0] !== 6'd62) begin errors++; $display("FAIL age_62: got %0d want 62", slot_age[5:0]); end
    repeat (4) step();
    checks++;
    if (slot_age[5:0] !== 6'd63) begin errors++; $display("FAIL age_63: got %0d want 63", slot_age[5:0]); end
    repeat (40) step();
    checks++;
    if (slot_age[5:0] !== 6'd63) begin errors++; $display("FAIL age_saturate: got %0d want 63", slot_age[5:0]); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_write = 1; in_prio = 2'(i % 4);
      in_addr = 28'h200 + 28'(i); in_data = 64'hD000 + 64'(i);
      step();
    end
    checks++;
    if (in_ready !== 1'b0 || count !== 5'd16 || slot_valid !== 16'hFFFF || slot_unsched[23:21] !== 3'b111) begin
      errors++;
      $display("FAIL fill_full: rdy=%b count=%0d valid=%h uns7=%b, want 0 16 ffff 111",
               in_ready, count, slot_valid, slot_unsched[23:21]);
    end
    in_addr = 28'hBAD; in_prio = 0; in_write = 0;
    step();
    idle_inputs();
    checks++;
    if (count !== 5'd16 || slot_unsched[2:0] !== 3'b001) begin
      errors++;
      $display("FAIL full_ignore: count=%0d uns0=%b, want 16 001", count, slot_unsched[2:0]);
    end
    issue_valid = 1; issue_slot = 5;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_write !== 1'b1 || out_addr !== 28'h205 || out_data !== 64'hD005 ||
        in_ready !== 1'b1 || slot_valid !== 16'hFFDF || count !== 5'd15) begin
      errors++;
      $display("FAIL retire5: ov=%b w=%b addr=%h data=%h rdy=%b valid=%h count=%0d, want 1 1 205 d005 1 ffdf 15",
               out_valid, out_write, out_addr, out_data, in_ready, slot_valid, count);
    end
    in_valid = 1; in_write = 0; in_prio = 1; in_addr = 28'h300;
    step();
    idle_inputs();
    checks++;
    if (slot_valid !== 16'hFFFF || slot_unsched[17:15] !== 3'b010 || slot_age[35:30] !== 6'd0 || count !== 5'd16) begin
      errors++;
      $display("FAIL refill5: valid=%h uns5=%b age5=%0d count=%0d, want ffff 010 0 16",
               slot_valid, slot_unsched[17:15], slot_age[35:30], count);
    end
  endtask

  task automatic test_simultaneous();
    issue_valid = 1; issue_slot = 15;
    step();
    idle_inputs();
    checks++;
    if (out_addr !== 28'h20F || slot_valid !== 16'h7FFF || count !== 5'd15) begin
      errors++;
      $display("FAIL free15: addr=%h valid=%h count=%0d, want 20f 7fff 15", out_addr, slot_valid, count);
    end
    issue_valid = 1; issue_slot = 3;
    in_valid = 1; in_write = 1; in_prio = 3; in_addr = 28'h400; in_data = 64'hABC;
    step();
    idle_inputs();
    checks++;
    if (slot_valid !== 16'hFFF7 || count !== 5'd15 || slot_unsched[47:45] !== 3'b111 ||
        slot_age[95:90] !== 6'd0 || slot_unsched[11:9] !== 3'b000) begin
      errors++;
      $display("FAIL simul_slots: valid=%h count=%0d uns15=%b age15=%0d uns3=%b, want fff7 15 111 0 000",
               slot_valid, count, slot_unsched[47:45], slot_age[95:90], slot_unsched[11:9]);
    end
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 28'h203 || out_data !== 64'hD003) begin
      errors++;
      $display("FAIL simul_out: ov=%b addr=%h data=%h, want 1 203 d003", out_valid, out_addr, out_data);
    end
  endtask

  task automatic test_empty_issue();
    logic [47:0] uns_before;
    uns_before = slot_unsched;
    issue_valid = 1; issue_slot = 3;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || issue_err !== 1'b1 || slot_valid !== 16'hFFF7 ||
        count !== 5'd15 || slot_unsched !== uns_before) begin
      errors++;
      $display("FAIL empty_issue: ov=%b err=%b valid=%h count=%0d, want 0 1 fff7 15",
               out_valid, issue_err, slot_valid, count);
    end
    repeat (3) step();
    checks++;
    if (issue_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", issue_err); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_slot = 0;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 28'h200) begin
      errors++;
      $display("FAIL pre_reset_pulse: ov=%b addr=%h, want 1 200", out_valid, out_addr);
    end
    #1 reset_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || slot_valid !== 16'h0 || count !== 5'd0 || issue_err !== 1'b0 || out_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid: ov=%b valid=%h count=%0d err=%b addr=%h, want 0 0000 0 0 0",
               out_valid, slot_valid, count, issue_err, out_addr);
    end
    step();
    reset_n = 1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1; in_addr = 28'hA0;
    step();
    in_addr = 28'hB0; issue_valid = 1; issue_slot = 0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 28'hA0 || slot_valid !== 16'h0002 || count !== 5'd1) begin
      errors++;
      $display("FAIL b2b_1: ov=%b addr=%h valid=%h count=%0d, want 1 a0 0002 1", out_valid, out_addr, slot_valid, count);
    end
    in_addr = 28'hC0; issue_slot = 1;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 28'hB0 || slot_valid !== 16'h0001 || count !== 5'd1) begin
      errors++;
      $display("FAIL b2b_2: ov=%b addr=%h valid=%h count=%0d, want 1 b0 0001 1", out_valid, out_addr, slot_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_insert();
    test_aging();
    test_fill();
    test_simultaneous();
    test_empty_issue();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
